ram_port_bist_ctrl: RTL and testbench

- March-test sequencer for one RAM port of the dpsram block.
- Drives the BIST override inputs of the port's bit-selection stage (bist_active, bist_wrdata, bist_bitmask) plus en/we/re/addr, and checks returned read data.
- Runs a fixed 4-element March sequence over all words, then reports pass/fail and the first failing address and element.
- Sits between the test/config controller and the port, one instance per port.

---
 rtl/ram_port_bist_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_ram_port_bist_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_bist_ctrl.sv
// March-test sequencer for one RAM port: M0 w(P), M1 r(P)w(~P) up, M2 r(~P)w(P) down, M3 r(P) up.
// Busy for 6N+RD_LAT cycles after start; no backpressure, reads are checked RD_LAT cycles later.
module ram_port_bist_ctrl #(
   parameter int                 ADDR_W  = 9,
   parameter int                 DATA_W  = 20,
   parameter int                 RD_LAT  = 1,
   parameter logic [DATA_W-1:0]  PATTERN = 20'hAAAAA
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] rddata_i,
   output logic              bist_active_o,
   output logic              en_o,
   output logic              we_o,
   output logic              re_o,
   output logic [15:0]       addr_o,
   output logic [DATA_W-1:0] wrdata_o,
   output logic [DATA_W-1:0] bitmask_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              fail_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [1:0]        fail_elem_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_DRAIN, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              phase_q, phase_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              fail_q, fail_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [1:0]        fail_elem_q, fail_elem_d;

   logic              pvld_q  [RD_LAT];
   logic              pvld_d  [RD_LAT];
   logic [DATA_W-1:0] pexp_q  [RD_LAT];
   logic [DATA_W-1:0] pexp_d  [RD_LAT];
   logic [ADDR_W-1:0] paddr_q [RD_LAT];
   logic [ADDR_W-1:0] paddr_d [RD_LAT];
   logic [1:0]        pelem_q [RD_LAT];
   logic [1:0]        pelem_d [RD_LAT];

   logic              busy, en, we, re;
   logic [DATA_W-1:0] wdat, exp_dat;
   logic [1:0]        elem;
   logic              mismatch;

   // Port drive decoded from state and the read/write phase of M1/M2.
   always_comb begin
      busy    = 1'b0;
      en      = 1'b0;
      we      = 1'b0;
      re      = 1'b0;
      wdat    = '0;
      exp_dat = '0;
      elem    = 2'd0;
      case (state_q)
         S_M0: begin
            busy = 1'b1; en = 1'b1; we = 1'b1; wdat = PATTERN;
         end
         S_M1: begin
            busy = 1'b1; en = 1'b1;
            if (!phase_q) begin
               re = 1'b1; exp_dat = PATTERN; elem = 2'd1;
            end else begin
               we = 1'b1; wdat = ~PATTERN;
            end
         end
         S_M2: begin
            busy = 1'b1; en = 1'b1;
            if (!phase_q) begin
               re = 1'b1; exp_dat = ~PATTERN; elem = 2'd2;
            end else begin
               we = 1'b1; wdat = PATTERN;
            end
         end
         S_M3: begin
            busy = 1'b1; en = 1'b1; re = 1'b1; exp_dat = PATTERN; elem = 2'd3;
         end
         S_DRAIN: busy = 1'b1;
         default: ;
      endcase
   end

   assign mismatch = pvld_q[RD_LAT-1] && (rddata_i != pexp_q[RD_LAT-1]);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      done_d      = done_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;

      pvld_d[0]  = re;
      pexp_d[0]  = exp_dat;
      paddr_d[0] = addr_q;
      pelem_d[0] = elem;
      for (int i = 1; i < RD_LAT; i++) begin
         pvld_d[i]  = pvld_q[i-1];
         pexp_d[i]  = pexp_q[i-1];
         paddr_d[i] = paddr_q[i-1];
         pelem_d[i] = pelem_q[i-1];
      end

      // Only the first mismatch is captured; the run always completes.
      if (mismatch) begin
         fail_d = 1'b1;
         if (!fail_q) begin
            fail_addr_d = paddr_q[RD_LAT-1];
            fail_elem_d = pelem_q[RD_LAT-1];
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d     = S_M0;
               addr_d      = '0;
               phase_d     = 1'b0;
               done_d      = 1'b0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_elem_d = 2'd0;
            end
         end
         S_M0: begin
            if (addr_q == LAST) begin
               state_d = S_M1;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_M1: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (addr_q == LAST) begin
                  state_d = S_M2;
                  addr_d  = LAST;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         S_M2: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (addr_q == '0) begin
                  state_d = S_M3;
               end else begin
                  addr_d = addr_q - 1'b1;
               end
            end
         end
         S_M3: begin
            if (addr_q == LAST) begin
               state_d = S_DRAIN;
               addr_d  = '0;
               cnt_d   = 2'd0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == 2'(RD_LAT - 1)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         phase_q     <= 1'b0;
         cnt_q       <= 2'd0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= 2'd0;
         for (int i = 0; i < RD_LAT; i++) begin
            pvld_q[i]  <= 1'b0;
            pexp_q[i]  <= '0;
            paddr_q[i] <= '0;
            pelem_q[i] <= 2'd0;
         end
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
         for (int i = 0; i < RD_LAT; i++) begin
            pvld_q[i]  <= pvld_d[i];
            pexp_q[i]  <= pexp_d[i];
            paddr_q[i] <= paddr_d[i];
            pelem_q[i] <= pelem_d[i];
         end
      end
   end

   assign bist_active_o = busy;
   assign busy_o        = busy;
   assign en_o          = en;
   assign we_o          = we;
   assign re_o          = re;
   assign addr_o        = en ? (16'(addr_q) << 5) : 16'd0;
   assign wrdata_o      = wdat;
   assign bitmask_o     = we ? '1 : '0;
   assign done_o        = done_q;
   assign fail_o        = fail_q;
   assign fail_addr_o   = fail_addr_q;
   assign fail_elem_o   = fail_elem_q;

endmodule

// File: tb/tb_ram_port_bist_ctrl.sv
// Two instances (RD_LAT=1 and RD_LAT=3) checked cycle by cycle against a March-order reference model.
module tb_ram_port_bist_ctrl;
   localparam int AW = 3;
   localparam int DW = 20;
   localparam int N  = 8;
   localparam logic [DW-1:0] P = 20'hAAAAA;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start1, start3, sel;
   logic [DW-1:0] rd1, rd3;
   logic act1, en1, we1, re1, busy1, done1, fail1;
   logic act3, en3, we3, re3, busy3, done3, fail3;
   logic [15:0] addr1, addr3;
   logic [DW-1:0] wr1, wr3, bm1, bm3;
   logic [AW-1:0] faddr1, faddr3;
   logic [1:0] felem1, felem3;

   ram_port_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PATTERN(P)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .rddata_i(rd1),
      .bist_active_o(act1), .en_o(en1), .we_o(we1), .re_o(re1), .addr_o(addr1),
      .wrdata_o(wr1), .bitmask_o(bm1), .busy_o(busy1), .done_o(done1), .fail_o(fail1),
      .fail_addr_o(faddr1), .fail_elem_o(felem1));

   ram_port_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .PATTERN(P)) dut3 (
      .clk_i(clk), .rst_i(rst), .start_i(start3), .rddata_i(rd3),
      .bist_active_o(act3), .en_o(en3), .we_o(we3), .re_o(re3), .addr_o(addr3),
      .wrdata_o(wr3), .bitmask_o(bm3), .busy_o(busy3), .done_o(done3), .fail_o(fail3),
      .fail_addr_o(faddr3), .fail_elem_o(felem3));

   // RAM models with an optional stuck-at bit on the read path.
   logic f_en;
   int   f_w, f_b;
   logic f_v;
   logic [DW-1:0] mem1 [N];
   logic [DW-1:0] mem3 [N];
   logic [DW-1:0] p3a, p3b;

   function automatic logic [DW-1:0] faulty(input logic [DW-1:0] d, input int a);
      logic [DW-1:0] r;
      r = d;
      if (f_en && a == f_w) r[f_b] = f_v;
      return r;
   endfunction

   always @(posedge clk) begin
      if (en1 && we1) mem1[addr1[7:5]] <= (mem1[addr1[7:5]] & ~bm1) | (wr1 & bm1);
      rd1 <= (en1 && re1) ? faulty(mem1[addr1[7:5]], int'(addr1[7:5])) : DW'($urandom);
   end

   always @(posedge clk) begin
      if (en3 && we3) mem3[addr3[7:5]] <= (mem3[addr3[7:5]] & ~bm3) | (wr3 & bm3);
      p3a <= (en3 && re3) ? faulty(mem3[addr3[7:5]], int'(addr3[7:5])) : DW'($urandom);
      p3b <= p3a;
      rd3 <= p3b;
   end

   logic [62:0] v1, v3, vo;
   logic [4:0]  fa1, fa3, fo;
   assign v1  = {act1, en1, we1, re1, addr1, wr1, bm1, busy1, done1, fail1};
   assign v3  = {act3, en3, we3, re3, addr3, wr3, bm3, busy3, done3, fail3};
   assign fa1 = {faddr1, felem1};
   assign fa3 = {faddr3, felem3};
   assign vo  = sel ? v3 : v1;
   assign fo  = sel ? fa3 : fa1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [62:0] obs, input logic [62:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Access k of the March run: write flag, read flag, word address, write/expected data.
   function automatic void acc(input int k, output logic w, output logic r,
                               output int a, output logic [DW-1:0] d);
      int j;
      w = 1'b0; r = 1'b0;
      if (k < N) begin
         w = 1'b1; a = k; d = P;
      end else if (k < 3*N) begin
         j = k - N; a = j / 2;
         if (j % 2 == 0) begin r = 1'b1; d = P; end else begin w = 1'b1; d = ~P; end
      end else if (k < 5*N) begin
         j = k - 3*N; a = N - 1 - j / 2;
         if (j % 2 == 0) begin r = 1'b1; d = ~P; end else begin w = 1'b1; d = P; end
      end else begin
         r = 1'b1; a = k - 5*N; d = P;
      end
   endfunction

   function automatic int first_fail();
      logic w, r; int a; logic [DW-1:0] d;
      for (int k = 0; k < 6*N; k++) begin
         acc(k, w, r, a, d);
         if (f_en && r && a == f_w && d[f_b] != f_v) return k;
      end
      return -1;
   endfunction

   function automatic logic [62:0] exp_vec(input int k, input int rl, input int kf);
      logic act, en, we, re, bz, dn, fl;
      logic [15:0] ad;
      logic [DW-1:0] wd, bm, d;
      int a;
      act = 0; en = 0; we = 0; re = 0; bz = 0; dn = 0; ad = '0; wd = '0; bm = '0;
      fl = (kf >= 0) && (k > kf + rl);
      if (k < 6*N) begin
         act = 1; bz = 1; en = 1;
         acc(k, we, re, a, d);
         ad = 16'(a) << 5;
         if (we) begin wd = d; bm = '1; end
      end else if (k < 6*N + rl) begin
         act = 1; bz = 1;
      end else begin
         dn = 1;
      end
      return {act, en, we, re, ad, wd, bm, bz, dn, fl};
   endfunction

   // One full run on the selected instance; optional extra start pulse and mid-run reset.
   task automatic run(input logic s, input int mid_start, input int abort_at);
      int rl, kf, el;
      rl = s ? 3 : 1;
      kf = first_fail();
      sel = s;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start1 = !s; start3 = s;
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      chk("start_clears_capture", 63'(fo), 63'(0));
      for (int k = 0; k <= 6*N + rl; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("cycle%0d_lat%0d", k, rl), vo, exp_vec(k, rl, kf));
         start1 = !s && (k == mid_start);
         start3 = s && (k == mid_start);
         if (k == abort_at) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_outputs", vo, 63'(0));
            chk("rst_capture", 63'(fo), 63'(0));
            @(negedge clk);
            rst = 1'b0;
            return;
         end
      end
      el = (kf < 0) ? 0 : (kf < 3*N) ? 1 : (kf < 5*N) ? 2 : 3;
      chk("fail_capture", 63'(fo), (kf < 0) ? 63'(0) : 63'({AW'(f_w), 2'(el)}));
   endtask

   initial begin
      rst = 1'b1; start1 = 1'b0; start3 = 1'b0; sel = 1'b0;
      f_en = 1'b0; f_w = 0; f_b = 0; f_v = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_dut1", v1, 63'(0));
      chk("reset_dut1_cap", 63'(fa1), 63'(0));
      chk("reset_dut3", v3, 63'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", v1, 63'(0));

      run(1'b0, -1, -1);

      f_en = 1'b1; f_w = 5; f_b = 3; f_v = 1'b0;
      run(1'b0, -1, -1);

      // Restart from DONE with fail set, plus an ignored start pulse inside M1.
      f_en = 1'b0;
      run(1'b0, N + 5, -1);

      for (int i = 0; i < 3; i++) begin
         f_en = 1'b1;
         f_w  = int'($urandom_range(0, N - 1));
         f_b  = int'($urandom_range(0, DW - 1));
         f_v  = 1'($urandom);
         run(1'b0, -1, -1);
      end

      f_en = 1'b0;
      run(1'b1, -1, -1);
      for (int i = 0; i < 2; i++) begin
         f_en = 1'b1;
         f_w  = int'($urandom_range(0, N - 1));
         f_b  = int'($urandom_range(0, DW - 1));
         f_v  = 1'($urandom);
         run(1'b1, 5*N + 2, -1);
      end

      f_en = 1'b0;
      run(1'b0, -1, 3*N + int'($urandom_range(0, 2*N - 1)));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_hold_dut1", v1, 63'(0));
         chk("idle_hold_dut3", v3, 63'(0));
      end
      run(1'b0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
